// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
// Imported by the controller and its LFSR.
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    GAP,
    OVER
  } state_t;

  localparam int NUM_MOLES  = 4;
  localparam int SCORE_W    = 8;
  localparam int LIVES_W    = 2;
  localparam int INTERVAL_W = 3;
  localparam int LFSR_W     = 8;

  // Right-shift Galois mask for x^8+x^6+x^5+x^4+1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  function automatic logic [NUM_MOLES-1:0] onehot(
    input logic [1:0] idx
  );
    return NUM_MOLES'(1) << idx;
  endfunction

endpackage

// File: rtl/whack_lfsr.sv
// 8-bit Galois LFSR; load reseeds, enable advances one step.
// Free-running source for the mole choice.
module whack_lfsr
  import whack_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              load,
  input  logic              enable,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] next;

  always_comb begin
    next = {1'b0, value[LFSR_W-1:1]};
    if (value[0]) next = next ^ LFSR_TAPS;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      value <= SEED;
    end else if (enable) begin
      value <= next;
    end
  end

endmodule

// File: rtl/whack_round_ctrl.sv
// Round sequencer for the whack-a-mole game: lights a mole,
// restarts the timer, scores hits/misses, levels up the interval.
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int unsigned      LIVES         = 3,
  parameter int unsigned      INIT_INTERVAL = 5,
  parameter int unsigned      MIN_INTERVAL  = 1,
  parameter int unsigned      LEVEL_HITS    = 4,
  parameter int unsigned      GAP_CYCLES    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_MOLES-1:0]  btn,
  input  logic                  timeout,
  output logic [INTERVAL_W-1:0] interval,
  output logic                  dir,
  output logic                  timer_clr,
  output logic [NUM_MOLES-1:0]  mole,
  output logic [SCORE_W-1:0]    score,
  output logic [LIVES_W-1:0]    lives,
  output logic                  hit,
  output logic                  miss,
  output logic                  game_over
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0] LVL_LAST =
    4'(LEVEL_HITS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT =
    LIVES_W'(LIVES);
  localparam logic [INTERVAL_W-1:0] INT_INIT =
    INTERVAL_W'(INIT_INTERVAL);
  localparam logic [INTERVAL_W-1:0] INT_MIN =
    INTERVAL_W'(MIN_INTERVAL);

  state_t                  state_q, state_d;
  logic [NUM_MOLES-1:0]    mole_q, mole_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [LIVES_W-1:0]      lives_q, lives_d;
  logic [INTERVAL_W-1:0]   intv_q, intv_d;
  logic [3:0]              level_q, level_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    hit_q, hit_d;
  logic                    miss_q, miss_d;
  logic                    clr_q, clr_d;
  logic                    over_q, over_d;
  logic [LFSR_W-1:0]       lfsr;
  logic                    btn_hit, btn_bad;
  logic                    unused_lfsr;

  whack_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .load  (rst),
    .enable(1'b1),
    .value (lfsr)
  );

  assign unused_lfsr = ^lfsr[LFSR_W-1:2];

  assign btn_hit = (btn == mole_q);
  assign btn_bad = (btn != '0) && !btn_hit;

  always_comb begin
    state_d  = state_q;
    mole_d   = mole_q;
    score_d  = score_q;
    lives_d  = lives_q;
    intv_d   = intv_q;
    level_d  = level_q;
    gap_d    = gap_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        mole_d = '0;
        if (start) begin
          state_d = ARM;
          score_d = '0;
          lives_d = LIVES_INIT;
          intv_d  = INT_INIT;
          level_d = '0;
        end
      end
      ARM: begin
        mole_d  = onehot(lfsr[1:0]);
        state_d = WAIT;
      end
      WAIT: begin
        gap_d = '0;
        // Correct press outranks a same-cycle timeout
        if (btn_hit) begin
          hit_d   = 1'b1;
          mole_d  = '0;
          state_d = GAP;
          if (score_q != '1) score_d = score_q + 1'b1;
          if (level_q == LVL_LAST) begin
            level_d = '0;
            if (intv_q > INT_MIN) intv_d = intv_q - 1'b1;
          end else begin
            level_d = level_q + 1'b1;
          end
        end else if (btn_bad || timeout) begin
          miss_d  = 1'b1;
          mole_d  = '0;
          lives_d = lives_q - 1'b1;
          state_d = (lives_q == 1) ? OVER : GAP;
        end
      end
      GAP: begin
        mole_d = '0;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ARM;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        mole_d  = '0;
        state_d = IDLE;
      end
    endcase
    clr_d  = (state_d == ARM);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mole_q  <= '0;
      score_q <= '0;
      lives_q <= LIVES_INIT;
      intv_q  <= INT_INIT;
      level_q <= '0;
      gap_q   <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      clr_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mole_q  <= mole_d;
      score_q <= score_d;
      lives_q <= lives_d;
      intv_q  <= intv_d;
      level_q <= level_d;
      gap_q   <= gap_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      clr_q   <= clr_d;
      over_q  <= over_d;
    end
  end

  assign interval  = intv_q;
  assign dir       = 1'b0;
  assign timer_clr = clr_q;
  assign mole      = mole_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Scoreboard bench for whack_round_ctrl: random rounds against
// a game-rule model; a monitor checks every hit/miss pulse.
module tb_whack_round_ctrl;
  import whack_pkg::*;

  localparam int LIVES_P = 3;
  localparam int INIT_P  = 5;
  localparam int MIN_P   = 1;
  localparam int LVL_P   = 4;
  localparam int GAP_P   = 16;
  localparam logic [7:0] SEED_P = 8'hA5;

  logic       clk, rst, start, timeout;
  logic [3:0] btn;
  logic [2:0] interval;
  logic       dir, timer_clr, hit, miss, game_over;
  logic [3:0] mole;
  logic [7:0] score;
  logic [1:0] lives;

  whack_round_ctrl #(
    .LIVES(LIVES_P), .INIT_INTERVAL(INIT_P),
    .MIN_INTERVAL(MIN_P), .LEVEL_HITS(LVL_P),
    .GAP_CYCLES(GAP_P), .LFSR_SEED(SEED_P)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn),
    .timeout(timeout), .interval(interval), .dir(dir),
    .timer_clr(timer_clr), .mole(mole), .score(score),
    .lives(lives), .hit(hit), .miss(miss),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_hit;
    int score;
    int lives;
    int interval;
    bit over;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;

  int  m_score, m_lives, m_hits;
  bit  m_over;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_step(logic [7:0] v);
    if (v[0]) return (v >> 1) ^ 8'hB8;
    return v >> 1;
  endfunction

  // Free-running reference of the random source
  always @(posedge clk)
    m_lfsr <= rst ? SEED_P : lfsr_step(m_lfsr);

  function automatic int exp_interval();
    int v;
    v = INIT_P - m_hits / LVL_P;
    return (v < MIN_P) ? MIN_P : v;
  endfunction

  task automatic model_reload();
    m_score = 0;
    m_lives = LIVES_P;
    m_hits  = 0;
    m_over  = 0;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d",
               name, act, exp);
    end
  endtask

  task automatic push_ev(input bit is_hit);
    if (is_hit) begin
      m_hits++;
      m_score = (m_score < 255) ? m_score + 1 : 255;
    end else begin
      m_lives--;
      m_over = (m_lives == 0);
    end
    exp_q.push_back('{is_hit, m_score, m_lives,
                      exp_interval(), m_over});
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst && (hit || miss)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: hit=%0b miss=%0b, none required",
                 hit, miss);
      end else begin
        e = exp_q.pop_front();
        check("ev_hit", hit, e.is_hit);
        check("ev_miss", miss, !e.is_hit);
        check("ev_score", score, e.score);
        check("ev_lives", lives, e.lives);
        check("ev_interval", interval, e.interval);
        check("ev_game_over", game_over, e.over);
        check("ev_mole_dark", mole, 0);
      end
    end
  end

  task automatic finish_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  endtask

  task automatic wait_arm(input bit noise);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (timer_clr) begin
        ok = 1;
        break;
      end
      if (noise && i < 6) begin
        btn     = 4'($urandom_range(1, 15));
        timeout = 1'($urandom_range(0, 1));
      end else begin
        btn     = '0;
        timeout = 1'b0;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL arm_wait: no timer_clr within 60 cycles");
      finish_all();
    end
  endtask

  task automatic play_round(input int action, input bit noise);
    logic [3:0] em, b;
    wait_arm(noise);
    check("arm_mole_dark", mole, 0);
    check("arm_score", score, m_score);
    check("arm_lives", lives, m_lives);
    check("arm_interval", interval, exp_interval());
    check("arm_game_over", game_over, 0);
    check("dir", dir, 0);
    em = 4'(1 << m_lfsr[1:0]);
    timeout = 1'($urandom_range(0, 1));
    @(negedge clk);
    timeout = 1'b0;
    check("wait_mole", mole, em);
    check("wait_clr_low", timer_clr, 0);
    case (action)
      0: begin btn = em; push_ev(1); end
      1: begin
        do b = 4'($urandom_range(1, 15)); while (b == em);
        btn = b;
        push_ev(0);
      end
      2: begin timeout = 1'b1; push_ev(0); end
      3: begin btn = em; timeout = 1'b1; push_ev(1); end
      4: begin
        do b = 4'(1 << $urandom_range(0, 3)); while (b == em);
        btn = em | b;
        push_ev(0);
      end
      default: begin
        repeat ($urandom_range(1, 5)) begin
          @(negedge clk);
          check("wait_hold_mole", mole, em);
        end
        btn = em;
        push_ev(1);
      end
    endcase
    @(negedge clk);
    btn     = '0;
    timeout = 1'b0;
  endtask

  task automatic over_phase();
    for (int i = 0; i < 6; i++) begin
      btn     = 4'($urandom_range(0, 15));
      timeout = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("over_flag", game_over, 1);
      check("over_mole", mole, 0);
      check("over_score", score, m_score);
      check("over_lives", lives, 0);
    end
    btn     = '0;
    timeout = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    model_reload();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mole"}, mole, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_lives"}, lives, LIVES_P);
    check({tag, "_interval"}, interval, INIT_P);
    check({tag, "_pulses"}, {hit, miss, timer_clr}, 0);
    check({tag, "_game_over"}, game_over, 0);
    check({tag, "_dir"}, dir, 0);
  endtask

  initial begin
    logic [3:0] em;
    rst = 1'b1; start = 1'b0; btn = '0; timeout = 1'b0;
    model_reload();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_pulses", {hit, miss, timer_clr}, 0);
    end
    check_reset_vals("idle");

    start_game();
    for (int i = 0; i < 20; i++) play_round(0, i[0]);

    play_round(1, 1);
    play_round(2, 1);
    play_round(3, 1);
    play_round(4, 1);
    over_phase();
    start_game();

    for (int i = 0; i < 60; i++) begin
      play_round($urandom_range(0, 5), 1);
      if (m_over) begin
        over_phase();
        start_game();
      end
    end

    wait_arm(0);
    em = 4'(1 << m_lfsr[1:0]);
    @(negedge clk);
    btn = em; timeout = 1'b1; rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0; btn = '0; timeout = 1'b0;
    model_reload();
    repeat (3) @(negedge clk);
    check_reset_vals("midrst_idle");

    start_game();
    for (int i = 0; i < 258; i++) play_round(0, 0);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    finish_all();
  end

endmodule
